// File: rtl/ro_puf_ctrl.sv
// ro_puf_ctrl: ring-oscillator PUF measurement sequencer.
// For each challenge it walks RESP_BITS RO pairs. Each pair goes through four phases:
// the two edge counters are cleared, the pair oscillates for WINDOW cycles, the pair
// settles with the ROs stopped, and then the frozen counts are compared. Each pair
// contributes one bit to the response.
// Optional feature macro: PUF_TIE_DETECT_EN. When it is defined, each comparison also flags
// near-equal counts in tie_mask. When it is undefined, tie_mask is tied to zero.
// Handshake: start is sampled only while idle, and a start seen while busy is dropped.
// done is a one-cycle pulse, and resp/tie_mask/err/sat are valid while done is high.
// Those outputs hold their value until the next accepted start.
module ro_puf_ctrl #(
    parameter int N_RO      = 16,
    parameter int SEL_W     = 4,
    parameter int CNT_W     = 16,
    parameter int RESP_BITS = 8,
    parameter int WINDOW    = 50000,
    parameter int SETTLE    = 8,
    parameter int TIE_THR   = 4
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*SEL_W-1:0]   chal,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [RESP_BITS-1:0] resp,
    output logic [RESP_BITS-1:0] tie_mask,
    output logic                 sat,
    output logic [N_RO-1:0]      ro_en,
    output logic [SEL_W-1:0]     sel_a,
    output logic [SEL_W-1:0]     sel_b,
    output logic                 cnt_clr,
    input  logic [CNT_W-1:0]     cnt_a,
    input  logic [CNT_W-1:0]     cnt_b
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RUN     = 3'd2,
        S_SETTLE  = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam int MAX_PH = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TMR_W  = $clog2(MAX_PH + 1);
    localparam int K_W    = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    localparam logic [TMR_W-1:0] WIN_LAST = TMR_W'(WINDOW - 1);
    localparam logic [TMR_W-1:0] SET_LAST = TMR_W'(SETTLE - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(RESP_BITS - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N_RO - 1);

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] tmr;
    logic [K_W-1:0]   k;
    logic             bad_chal;
    logic [SEL_W-1:0] idx_a;
    logic [SEL_W-1:0] idx_b;
    logic             accept;
    logic             last_pair;

    assign idx_a     = chal[2*SEL_W-1:SEL_W];
    assign idx_b     = chal[SEL_W-1:0];
    assign accept    = (state == S_IDLE) && start;
    assign last_pair = (k == K_LAST);

    // Advance an RO index with wrap-around. The compare handles N_RO values that are not a power of two.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] i);
        if (i >= IDX_LAST) begin
            return '0;
        end
        return i + SEL_W'(1);
    endfunction

    // State register; async reset drops the ROs and aborts any measurement.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    // A rejected challenge passes through CLEAR for a single cycle, with the clear gated off.
    // The equal-index check therefore runs on the latched challenge.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_CLEAR;
            S_CLEAR:   if (bad_chal) state_nxt = S_DONE;
                       else if (tmr == SET_LAST) state_nxt = S_RUN;
            S_RUN:     if (tmr == WIN_LAST) state_nxt = S_SETTLE;
            S_SETTLE:  if (tmr == SET_LAST) state_nxt = S_COMPARE;
            S_COMPARE: state_nxt = last_pair ? S_DONE : S_CLEAR;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Output decode from state and the current pair selects.
    always_comb begin
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        cnt_clr = (state == S_CLEAR) && !bad_chal;
        ro_en   = '0;
        if (state == S_RUN) begin
            ro_en[sel_a] = 1'b1;
            ro_en[sel_b] = 1'b1;
        end
    end

    // Phase timer restarts on every state change and stays at zero while idle, so it never wraps.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            tmr <= '0;
        end else if (state == S_IDLE || state_nxt != state) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + TMR_W'(1);
        end
    end

    // Challenge latch, pair walk and response assembly.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sel_a    <= '0;
            sel_b    <= '0;
            k        <= '0;
            resp     <= '0;
            err      <= 1'b0;
            sat      <= 1'b0;
            bad_chal <= 1'b0;
        end else if (accept) begin
            sel_a    <= idx_a;
            sel_b    <= idx_b;
            k        <= '0;
            resp     <= '0;
            sat      <= 1'b0;
            err      <= (idx_a == idx_b);
            bad_chal <= (idx_a == idx_b);
        end else if (state == S_COMPARE) begin
            resp[k] <= (cnt_a > cnt_b);
            sat     <= sat | (&cnt_a) | (&cnt_b);
            if (!last_pair) begin
                k     <= k + K_W'(1);
                sel_a <= next_idx(sel_a);
                sel_b <= next_idx(sel_b);
            end
        end
    end

`ifdef PUF_TIE_DETECT_EN
    logic [CNT_W:0] diff_ab;
    logic [CNT_W:0] diff_ba;
    logic [CNT_W:0] mag;
    logic           tie_now;

    // Unsigned distance between the frozen counts. One extra bit holds the borrow.
    always_comb begin
        diff_ab = {1'b0, cnt_a} - {1'b0, cnt_b};
        diff_ba = {1'b0, cnt_b} - {1'b0, cnt_a};
        mag     = diff_ab[CNT_W] ? diff_ba : diff_ab;
        tie_now = (mag < (CNT_W+1)'(TIE_THR));
    end

    // Per-bit tie flags, cleared on accept and captured alongside resp.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            tie_mask <= '0;
        end else if (accept) begin
            tie_mask <= '0;
        end else if (state == S_COMPARE) begin
            tie_mask[k] <= tie_now;
        end
    end
`else
    assign tie_mask = '0;
`endif

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Directed bench for ro_puf_ctrl, using a short window (WINDOW=10, SETTLE=2, RESP_BITS=4).
// The counter inputs come from a per-RO count table (count = 2000 - 10*index).
// Alternatively, fixed values can be forced onto both counters.
module tb_ro_puf_ctrl;

    localparam int N_RO      = 16;
    localparam int SEL_W     = 4;
    localparam int CNT_W     = 16;
    localparam int RESP_BITS = 4;
    localparam int WINDOW    = 10;
    localparam int SETTLE    = 2;
    localparam int TIE_THR   = 4;
    localparam int LAT_OK    = RESP_BITS * (2*SETTLE + WINDOW + 1) + 1;

    logic                 CLK;
    logic                 rst_n;
    logic                 start;
    logic [2*SEL_W-1:0]   chal;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [RESP_BITS-1:0] resp;
    logic [RESP_BITS-1:0] tie_mask;
    logic                 sat;
    logic [N_RO-1:0]      ro_en;
    logic [SEL_W-1:0]     sel_a;
    logic [SEL_W-1:0]     sel_b;
    logic                 cnt_clr;
    logic [CNT_W-1:0]     cnt_a;
    logic [CNT_W-1:0]     cnt_b;

    logic                 use_fixed;
    logic [CNT_W-1:0]     fix_a;
    logic [CNT_W-1:0]     fix_b;

    int n_checks;
    int n_fail;

    logic [7:0] exp_q[$];
    logic [7:0] seen_q[$];
    int         bad_en;
    int         ndone;
    int         lat;
    logic [RESP_BITS-1:0] exp_tie;

    ro_puf_ctrl #(
        .N_RO(N_RO), .SEL_W(SEL_W), .CNT_W(CNT_W), .RESP_BITS(RESP_BITS),
        .WINDOW(WINDOW), .SETTLE(SETTLE), .TIE_THR(TIE_THR)
    ) dut (
        .CLK(CLK), .rst_n(rst_n), .start(start), .chal(chal),
        .busy(busy), .done(done), .err(err), .resp(resp), .tie_mask(tie_mask),
        .sat(sat), .ro_en(ro_en), .sel_a(sel_a), .sel_b(sel_b), .cnt_clr(cnt_clr),
        .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RO bank model: each RO has a fixed count for the window
    function automatic logic [CNT_W-1:0] ro_count(input logic [SEL_W-1:0] i);
        return CNT_W'(2000 - 10 * int'(i));
    endfunction

    assign cnt_a = use_fixed ? fix_a : ro_count(sel_a);
    assign cnt_b = use_fixed ? fix_b : ro_count(sel_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_len"}, 32'(seen_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
            check($sformatf("%s_%0d", tag, i), {24'd0, seen_q[i]}, {24'd0, exp_q[i]});
        end
    endtask

    // driver: issue one challenge from a negedge and watch until done (bounded)
    task automatic run_chal(input logic [7:0] c, input bit poke, output int lat_o);
        int n;
        bit prev_run;
        bit got;
        seen_q.delete();
        bad_en = 0;
        ndone  = 0;
        chal   = c;
        start  = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start    = 1'b0;
        n        = 1;
        prev_run = 1'b0;
        got      = 1'b0;
        lat_o    = -1;
        while (n < 3000 && !got) begin
            if (ro_en != '0) begin
                if ($countones(ro_en) != 2) bad_en++;
                if (!prev_run) seen_q.push_back({sel_a, sel_b});
            end
            prev_run = (ro_en != '0);
            if (poke && n == 20) start = 1'b1;
            if (poke && n == 21) start = 1'b0;
            if (done) begin
                got   = 1'b1;
                lat_o = n;
                ndone++;
            end else begin
                @(negedge CLK);
                n++;
            end
        end
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (done) ndone++;
        end
    endtask

    initial begin
        int runs;
        bit prev_run;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        chal      = '0;
        use_fixed = 1'b0;
        fix_a     = '0;
        fix_b     = '0;

        // reset state
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        check("rst_clr", 32'(cnt_clr), 32'd0);
        check("rst_resp", 32'(resp), 32'd0);
        check("rst_tie", 32'(tie_mask), 32'd0);
        check("rst_ro_en", 32'(ro_en), 32'd0);
        check("rst_sel_a", 32'(sel_a), 32'd0);
        check("rst_sel_b", 32'(sel_b), 32'd0);
        @(negedge CLK);
        rst_n = 1'b1;
        @(negedge CLK);

        // A > B on every pair: 1980>1950, 1970>1940, 1960>1930, 1950>1920
        run_chal({4'd2, 4'd5}, 1'b0, lat);
        check("a_lat", 32'(lat), 32'(LAT_OK));
        check("a_resp", 32'(resp), 32'hF);
        check("a_err", 32'(err), 32'd0);
        check("a_sat", 32'(sat), 32'd0);
        check("a_tie", 32'(tie_mask), 32'd0);
        check("a_ndone", 32'(ndone), 32'd1);
        check("a_two_en", 32'(bad_en), 32'd0);
        check("a_busy_after", 32'(busy), 32'd0);
        exp_q = '{8'h25, 8'h36, 8'h47, 8'h58};
        check_seq("a_sel");

        // wrap-around: pairs (15,14) (0,15) (1,0) (2,1) -> only pair 1 has A > B
        run_chal({4'd15, 4'd14}, 1'b0, lat);
        check("b_lat", 32'(lat), 32'(LAT_OK));
        check("b_resp", 32'(resp), 32'h2);
        check("b_two_en", 32'(bad_en), 32'd0);
        exp_q = '{8'hFE, 8'h0F, 8'h10, 8'h21};
        check_seq("b_sel");

        // rejected challenge
        run_chal({4'd7, 4'd7}, 1'b0, lat);
        check("c_lat", 32'(lat), 32'd2);
        check("c_err", 32'(err), 32'd1);
        check("c_resp", 32'(resp), 32'd0);
        check("c_ro_en_runs", 32'(seen_q.size()), 32'd0);
        check("c_ndone", 32'(ndone), 32'd1);

        // saturated, equal counts plus a stray start during RUN
        use_fixed = 1'b1;
        fix_a     = 16'hFFFF;
        fix_b     = 16'hFFFF;
        run_chal({4'd2, 4'd5}, 1'b1, lat);
        check("d_lat", 32'(lat), 32'(LAT_OK));
        check("d_ndone", 32'(ndone), 32'd1);
        check("d_resp", 32'(resp), 32'd0);
        check("d_sat", 32'(sat), 32'd1);
        check("d_err", 32'(err), 32'd0);

        // near-equal counts 1000/1003
        fix_a = 16'd1000;
        fix_b = 16'd1003;
`ifdef PUF_TIE_DETECT_EN
        exp_tie = 4'hF;
`else
        exp_tie = 4'h0;
`endif
        run_chal({4'd1, 4'd9}, 1'b0, lat);
        check("e_resp", 32'(resp), 32'd0);
        check("e_tie", 32'(tie_mask), 32'(exp_tie));
        check("e_sat", 32'(sat), 32'd0);

        // distance 4 is not a tie
        fix_a = 16'd1004;
        fix_b = 16'd1000;
        run_chal({4'd1, 4'd9}, 1'b0, lat);
        check("f_resp", 32'(resp), 32'hF);
        check("f_tie", 32'(tie_mask), 32'd0);
        repeat (10) @(negedge CLK);
        check("f_resp_hold", 32'(resp), 32'hF);
        use_fixed = 1'b0;

        // reset during RUN of pair k=3
        chal  = {4'd2, 4'd5};
        start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start    = 1'b0;
        runs     = 0;
        prev_run = 1'b0;
        for (int i = 0; i < 200 && runs < 4; i++) begin
            if (ro_en != '0 && !prev_run) runs++;
            prev_run = (ro_en != '0);
            if (runs < 4) @(negedge CLK);
        end
        check("g_reached_k3", 32'(runs), 32'd4);
        repeat (3) @(negedge CLK);
        #2 rst_n = 1'b0;
        #1;
        check("g_ro_en", 32'(ro_en), 32'd0);
        check("g_busy", 32'(busy), 32'd0);
        check("g_clr", 32'(cnt_clr), 32'd0);
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (done) ndone++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (done) ndone++;
        end
        check("g_no_done", 32'(ndone), 32'd0);
        check("g_resp_clr", 32'(resp), 32'd0);
        run_chal({4'd2, 4'd5}, 1'b0, lat);
        check("g_after_lat", 32'(lat), 32'(LAT_OK));
        check("g_after_resp", 32'(resp), 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
